// File: rtl/control_fetch_if.sv
// Fetch-stage controller: owns the PC and produces the IF/ID word,
// sequencing decode stalls, branch bubbles and HALT.
module control_fetch_if #(
  parameter int PC_WIDTH = 8,
  parameter int INSTR_WIDTH = 14,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD = '0,
  parameter logic [3:0] HALT_OPCODE = 4'hF,
  parameter int BRANCH_BUBBLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_id,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic [INSTR_WIDTH-1:0] instr_mem,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instruction_if,
  output logic                   fetch_valid,
  output logic                   halted
);

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH,
    HALT
  } state_t;

  localparam logic [2:0] BB_M1 = 3'(BRANCH_BUBBLES - 1);

  state_t                   state, state_nx;
  logic [2:0]               cnt, cnt_nx;
  logic [PC_WIDTH-1:0]      pc_nx;
  logic [INSTR_WIDTH-1:0]   instr_nx;
  logic                     valid_nx;
  logic                     halted_nx;
  logic                     halt_op;
  logic                     fetch_ok;

  assign halt_op = instr_mem[INSTR_WIDTH-1 -: 4] == HALT_OPCODE;

  // FLUSH with an exhausted counter behaves like RUN for this cycle
  assign fetch_ok = (state == RUN) || (state == STALL) ||
                    ((state == FLUSH) && (cnt == 3'd0));

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    pc_nx     = pc;
    instr_nx  = instruction_if;
    valid_nx  = fetch_valid;
    halted_nx = halted;
    if (state == HALT) begin
      instr_nx  = NOP_WORD;
      valid_nx  = 1'b0;
      halted_nx = 1'b1;
    end else if (branch_taken) begin
      pc_nx    = branch_target;
      instr_nx = NOP_WORD;
      valid_nx = 1'b0;
      cnt_nx   = BB_M1;
      state_nx = (BRANCH_BUBBLES > 1) ? FLUSH : RUN;
    end else if (!fetch_ok) begin
      instr_nx = NOP_WORD;
      valid_nx = 1'b0;
      cnt_nx   = cnt - 3'd1;
    end else if (stall_id) begin
      state_nx = STALL;
    end else if (halt_op) begin
      instr_nx = instr_mem;
      valid_nx = 1'b1;
      state_nx = HALT;
    end else begin
      instr_nx = instr_mem;
      valid_nx = 1'b1;
      pc_nx    = pc + PC_WIDTH'(1);
      state_nx = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      cnt            <= 3'd0;
      pc             <= '0;
      instruction_if <= NOP_WORD;
      fetch_valid    <= 1'b0;
      halted         <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      pc             <= pc_nx;
      instruction_if <= instr_nx;
      fetch_valid    <= valid_nx;
      halted         <= halted_nx;
    end
  end

endmodule

// File: tb/tb_control_fetch_if.sv
// Bench for control_fetch_if: directed scenarios plus random traffic,
// checked against a flat priority model with a bubble countdown.
module tb_control_fetch_if;

  localparam int BB = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_id = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = '0;
  logic [13:0] instr_mem;
  logic [7:0]  pc;
  logic [13:0] instruction_if;
  logic        fetch_valid;
  logic        halted;

  logic [13:0] mem [256];

  int total = 0;
  int bad = 0;

  // reference state
  logic [7:0]  m_pc = '0;
  logic [13:0] m_ins = '0;
  logic        m_v = 1'b0;
  logic        m_h = 1'b0;
  logic        m_stop = 1'b0;
  int          m_bub = 0;

  always #5 clk = ~clk;

  assign instr_mem = mem[pc];

  control_fetch_if #(
    .PC_WIDTH(8),
    .INSTR_WIDTH(14),
    .NOP_WORD(14'h0000),
    .HALT_OPCODE(4'hF),
    .BRANCH_BUBBLES(BB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall_id(stall_id),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .instr_mem(instr_mem),
    .pc(pc),
    .instruction_if(instruction_if),
    .fetch_valid(fetch_valid),
    .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b,
                      input logic [7:0] t);
    logic [13:0] cur;
    @(negedge clk);
    reset = r;
    stall_id = s;
    branch_taken = b;
    branch_target = t;
    cur = mem[m_pc];
    @(posedge clk);
    if (r) begin
      m_pc = '0; m_ins = '0; m_v = 0;
      m_h = 0; m_stop = 0; m_bub = 0;
    end else if (m_stop) begin
      m_h = 1; m_ins = '0; m_v = 0;
    end else if (b) begin
      m_pc = t; m_ins = '0; m_v = 0; m_bub = BB - 1;
    end else if (m_bub > 0) begin
      m_bub--; m_ins = '0; m_v = 0;
    end else if (s) begin
      // everything held
    end else if (cur[13:10] == 4'hF) begin
      m_ins = cur; m_v = 1; m_stop = 1;
    end else begin
      m_ins = cur; m_v = 1; m_pc = m_pc + 8'd1;
    end
    #1;
    check("pc", 32'(pc), 32'(m_pc));
    check("instr", 32'(instruction_if), 32'(m_ins));
    check("valid", 32'(fetch_valid), 32'(m_v));
    check("halted", 32'(halted), 32'(m_h));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 14'h0100 + 14'(a);

    // reset then free run up to pc=5
    step(1, 0, 0, 8'h00);
    check("rst_pc", 32'(pc), 32'h0);
    run(5);
    // stall three cycles at pc=5
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
    run(5);
    // branch at pc=10 to 0x40
    step(0, 0, 1, 8'h40);
    run(3);
    // branch with concurrent stall
    step(0, 1, 1, 8'h40);
    step(0, 1, 0, 8'h00);
    run(2);
    // wrap through all-ones
    step(0, 0, 1, 8'hFE);
    run(5);
    // HALT word at address 3
    mem[3] = 14'h3C00;
    step(1, 0, 0, 8'h00);
    run(6);
    step(0, 0, 1, 8'h20);
    step(0, 1, 0, 8'h00);
    check("halt_hold", 32'(halted), 32'h1);
    step(1, 0, 0, 8'h00);
    mem[3] = 14'h0103;
    run(2);
    // reset during FLUSH
    step(0, 0, 1, 8'h80);
    step(1, 0, 0, 8'h00);
    run(3);
    // reset during STALL
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(1, 1, 0, 8'h00);
    run(3);

    // random traffic
    for (int a = 0; a < 256; a++) begin
      logic [13:0] w;
      w = 14'($urandom);
      if (w[13:10] == 4'hF && ($urandom % 8) != 0) w[13] = 1'b0;
      mem[a] = w;
    end
    for (int i = 0; i < 600; i++) begin
      logic r, s, b;
      r = ($urandom % 100) < (m_stop ? 15 : 2);
      s = ($urandom % 4) == 0;
      b = ($urandom % 10) == 0;
      step(r, s, b, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
